adder_nbit_seq: RTL and testbench

//  Parametrised multi-cycle ripple adder with start/done handshake. Adds two NUM_BITS operands plus carry-in.

---
 rtl/adder_nbit_seq.sv | 107 ++++++++++
 tb/tb_adder_nbit_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_nbit_seq.sv
// Multi-cycle ripple adder: adds CHUNK_BITS per clock, LS chunk first.
// start/done handshake; sum and overflow are held until the next completion.
module adder_nbit_seq #(
    parameter int NUM_BITS   = 16,
    parameter int CHUNK_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);

    localparam int K     = NUM_BITS / CHUNK_BITS;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(K - 1);
    localparam logic [NUM_BITS-1:0] MASK = NUM_BITS'({CHUNK_BITS{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NUM_BITS-1:0] a_r, b_r, work;
    logic                carry_r;
    logic [IDX_W-1:0]    idx;

    logic [CHUNK_BITS-1:0] a_ch, b_ch, s_ch;
    logic                  c_out;
    logic [NUM_BITS-1:0]   work_next;
    int unsigned           sh;

    always_comb begin
        sh           = idx * CHUNK_BITS;
        a_ch         = CHUNK_BITS'(a_r >> sh);
        b_ch         = CHUNK_BITS'(b_r >> sh);
        {c_out, s_ch} = {1'b0, a_ch} + {1'b0, b_ch}
                      + {{CHUNK_BITS{1'b0}}, carry_r};
        // working sum with the current slice already merged in
        work_next = (work & ~(MASK << sh))
                  | (NUM_BITS'(s_ch) << sh);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = ADD;
            ADD:  if (idx == LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            idx      <= '0;
            work     <= '0;
            sum      <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= carry_in;
                        idx     <= '0;
                    end
                end
                ADD: begin
                    work    <= work_next;
                    carry_r <= c_out;
                    if (idx == LAST) begin
                        sum      <= work_next;
                        overflow <= c_out;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_adder_nbit_seq.sv
// Bench for adder_nbit_seq: 16/4 instance plus an 8/8 (single chunk) instance.
// Results are compared with plain a+b+cin arithmetic.
module tb_adder_nbit_seq;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        carry_in = 1'b0;
    logic        busy, done, overflow;
    logic [15:0] sum;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, ovf8;
    logic [7:0] sum8;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    adder_nbit_seq #(.NUM_BITS(16), .CHUNK_BITS(4)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .a(a), .b(b), .carry_in(carry_in),
        .busy(busy), .done(done), .sum(sum), .overflow(overflow)
    );

    adder_nbit_seq #(.NUM_BITS(8), .CHUNK_BITS(8)) dut8 (
        .clk(clk), .n_rst(n_rst), .start(start8),
        .a(a8), .b(b8), .carry_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .overflow(ovf8)
    );

    // lat = edges after the start-sampling edge until done is seen
    task automatic op16(input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, output logic [15:0] os,
                        output logic oov, output int lat,
                        output int busy_n);
        @(negedge clk);
        a = ia; b = ib; carry_in = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
        lat = 0;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_n++;
        end
        os = sum; oov = overflow;
        @(posedge clk); #1;
        if (busy) busy_n++;
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, output logic [7:0] os,
                       output logic oov, output int lat);
        @(negedge clk);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        os = sum8; oov = ovf8;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({busy, done, sum, overflow} !== 19'd0) begin
            bad++;
            $display("FAIL reset: got busy=%b done=%b sum=%h ovf=%b want 0",
                     busy, done, sum, overflow);
        end
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero;
        logic [15:0] s; logic o; int lat, bn;
        op16(16'h0000, 16'h0000, 1'b0, s, o, lat, bn);
        total++;
        if (lat !== 4) begin
            bad++; $display("FAIL zero_latency: got %0d want 4", lat);
        end
        total++;
        if ({o, s} !== 17'd0) begin
            bad++; $display("FAIL zero_sum: got %b_%h want 0_0000", o, s);
        end
        total++;
        if (bn !== 5) begin
            bad++; $display("FAIL zero_busy: got %0d cycles want 5", bn);
        end
    endtask

    task automatic test_vectors;
        logic [15:0] va [5] = '{16'hFFFA, 16'h0001, 16'hAAFF, 16'hFFFF, 16'h8000};
        logic [15:0] vb [5] = '{16'h0001, 16'hFFFA, 16'hFFAA, 16'h0000, 16'h8000};
        logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [16:0] ex [5] = '{17'h0FFFB, 17'h0FFFB, 17'h1AAA9, 17'h10000, 17'h10001};
        logic [15:0] s; logic o; int lat, bn;
        for (int i = 0; i < 5; i++) begin
            op16(va[i], vb[i], vc[i], s, o, lat, bn);
            total++;
            if ({o, s} !== ex[i]) begin
                bad++;
                $display("FAIL vec%0d: got %b_%h want %b_%h",
                         i, o, s, ex[i][16], ex[i][15:0]);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int d0, lat;
        logic [16:0] exp_v;
        exp_v = {1'b0, 16'h0F0F} + {1'b0, 16'h7123} + 17'd1;
        d0 = done_cnt;
        @(negedge clk);
        a = 16'h0F0F; b = 16'h7123; carry_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if ({overflow, sum} !== exp_v) begin
            bad++;
            $display("FAIL busy_start: got %b_%h want %b_%h",
                     overflow, sum, exp_v[16], exp_v[15:0]);
        end
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL busy_start_pulses: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        int hits[$];
        logic [16:0] exp_v;
        int ok;
        exp_v = {1'b0, 16'hC3A5} + {1'b0, 16'h5A5A} + 17'd1;
        @(negedge clk);
        a = 16'hC3A5; b = 16'h5A5A; carry_in = 1'b1; start = 1'b1;
        ok = 1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) begin
                hits.push_back(c);
                if ({overflow, sum} !== exp_v) ok = 0;
            end
        end
        @(negedge clk); start = 1'b0;
        repeat (8) @(posedge clk);
        total++;
        if (hits.size() < 4 || hits[0] !== 4) begin
            bad++;
            $display("FAIL b2b_first: got n=%0d first=%0d want n>=4 first=4",
                     hits.size(), hits.size() > 0 ? hits[0] : -1);
        end
        for (int i = 1; i < hits.size(); i++) begin
            total++;
            if (hits[i] - hits[i-1] !== 6) begin
                bad++;
                $display("FAIL b2b_gap%0d: got %0d want 6", i, hits[i] - hits[i-1]);
            end
        end
        total++;
        if (ok !== 1) begin
            bad++; $display("FAIL b2b_sum: got wrong result want %h", exp_v);
        end
    endtask

    task automatic test_reset_mid_op;
        int d0;
        @(negedge clk);
        a = 16'h1357; b = 16'h2468; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, overflow} !== 19'd0) begin
            bad++;
            $display("FAIL mid_reset: got busy=%b done=%b sum=%h ovf=%b want 0",
                     busy, done, sum, overflow);
        end
        d0 = done_cnt;
        @(negedge clk); n_rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_quiet: got pulses=%0d busy=%b want 0 0",
                     done_cnt - d0, busy);
        end
    endtask

    task automatic test_single_chunk;
        logic [7:0] s; logic o; int lat;
        logic [8:0] ex;
        op8(8'hFF, 8'h01, 1'b0, s, o, lat);
        total++;
        if ({o, s} !== 9'h100 || lat !== 1) begin
            bad++;
            $display("FAIL k1_ff01: got %b_%h lat=%0d want 1_00 lat=1", o, s, lat);
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ra, rb; logic rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            ex = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            op8(ra, rb, rc, s, o, lat);
            total++;
            if ({o, s} !== ex) begin
                bad++;
                $display("FAIL k1_rand%0d: %h+%h+%b got %b_%h want %b_%h",
                         i, ra, rb, rc, o, s, ex[8], ex[7:0]);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] s; logic o; int lat, bn;
        logic [16:0] ex;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb; logic rc;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
            ex = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            op16(ra, rb, rc, s, o, lat, bn);
            total++;
            if ({o, s} !== ex || lat !== 4) begin
                bad++;
                $display("FAIL rand%0d: %h+%h+%b got %b_%h lat=%0d want %b_%h lat=4",
                         i, ra, rb, rc, o, s, lat, ex[16], ex[15:0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_vectors;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_op;
        test_single_chunk;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
